// File: rtl/imem_boot_arbiter_if.sv
// Bus bundle between the boot loader, the CPU fetch port, the instruction RAM and the arbiter.
// The arbiter takes the slave modport; the master modport is the loader/CPU/RAM side.
interface imem_boot_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [3:0]    b_be;
  logic          b_gnt;

  logic          c_req;
  logic [AW-1:0] c_addr;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  b_req, b_we, b_addr, b_wdata, b_be,
    output b_gnt,
    input  c_req, c_addr,
    output c_gnt, c_rvalid, c_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output b_req, b_we, b_addr, b_wdata, b_be,
    input  b_gnt,
    output c_req, c_addr,
    input  c_gnt, c_rvalid, c_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/imem_boot_arbiter.sv
// Hands the single-port instruction RAM to the UART boot loader while it holds the core in reset,
// and back to CPU fetch otherwise; ownership only moves once outstanding CPU reads have returned.
module imem_boot_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                boot_active_i,
  imem_boot_arbiter_if.slave  bus,
  output logic                owner_boot_o,
  output logic [31:0]         boot_wr_cnt_o,
  output logic [7:0]          boot_err_cnt_o
);

  typedef enum logic [1:0] {CPU_OWN, DRAIN, BOOT_OWN, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [MEM_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [31:0]        wr_cnt_q, wr_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               c_gnt, b_gnt;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= CPU_OWN;
    else     state_q <= state_d;
  end

  // An abort (boot_active dropping) wins over a finished drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_OWN:  if (boot_active_i) state_d = DRAIN;
      DRAIN: begin
        if (!boot_active_i)         state_d = CPU_OWN;
        else if (rd_pipe_q == '0)   state_d = BOOT_OWN;
      end
      BOOT_OWN: if (!boot_active_i) state_d = RELEASE;
      RELEASE:  state_d = CPU_OWN;
      default:  state_d = CPU_OWN;
    endcase
  end

  always_comb begin
    c_gnt         = 1'b0;
    b_gnt         = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.c_addr;
    bus.mem_wdata = '0;
    bus.mem_be    = 4'hF;
    case (state_q)
      CPU_OWN: begin
        c_gnt       = bus.c_req & ~boot_active_i;
        bus.mem_req = c_gnt;
      end
      BOOT_OWN: begin
        b_gnt         = bus.b_req;
        bus.mem_req   = bus.b_req & bus.b_we;
        bus.mem_we    = bus.b_we;
        bus.mem_addr  = bus.b_addr;
        bus.mem_wdata = bus.b_wdata;
        bus.mem_be    = bus.b_be;
      end
      default: ;
    endcase
    // Reset must silence every handshake regardless of the (possibly stale) state.
    if (Rst) begin
      c_gnt       = 1'b0;
      b_gnt       = 1'b0;
      bus.mem_req = 1'b0;
    end
  end

  always_comb begin
    rd_pipe_d = (rd_pipe_q << 1) | MEM_LAT'(c_gnt);
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == DRAIN && state_d == BOOT_OWN) wr_cnt_d = '0;
    else if (b_gnt && bus.b_we)                  wr_cnt_d = wr_cnt_q + 32'd1;
    if (b_gnt && !bus.b_we && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_pipe_q <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_pipe_q <= rd_pipe_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.c_rvalid = rd_pipe_q[MEM_LAT-1] & ~Rst;
  assign bus.c_rdata  = bus.mem_rdata;

  assign owner_boot_o   = (state_q == BOOT_OWN);
  assign boot_wr_cnt_o  = wr_cnt_q;
  assign boot_err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter: reset, drain, boot load, error path, release, abort, mid-read reset.
module tb_imem_boot_arbiter;

  logic        Clk;
  logic        Rst;
  logic        bootActive;
  logic [31:0] bootWrCnt;
  logic [7:0]  bootErrCnt;
  logic        ownerBoot;
  logic [31:0] ram [0:255];
  logic [31:0] ramRdata;
  int          checks;
  int          failures;

  imem_boot_arbiter_if #(.AW(32), .DW(32)) bus ();

  imem_boot_arbiter #(.MEM_LAT(1)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .boot_active_i (bootActive),
    .bus           (bus),
    .owner_boot_o  (ownerBoot),
    .boot_wr_cnt_o (bootWrCnt),
    .boot_err_cnt_o(bootErrCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single-cycle-latency byte-enabled RAM
  always @(posedge Clk) begin
    if (bus.mem_req) begin
      if (bus.mem_we) begin
        for (int k = 0; k < 4; k++)
          if (bus.mem_be[k]) ram[bus.mem_addr[9:2]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
      end else begin
        ramRdata <= ram[bus.mem_addr[9:2]];
      end
    end
  end
  assign bus.mem_rdata = ramRdata;

  task automatic applyStimulus(input logic rst, input logic ba, input logic breq, input logic bwe,
                               input logic [31:0] baddr, input logic [31:0] bwdata,
                               input logic [3:0] bbe, input logic creq, input logic [31:0] caddr);
    @(negedge Clk);
    Rst         = rst;
    bootActive  = ba;
    bus.b_req   = breq;
    bus.b_we    = bwe;
    bus.b_addr  = baddr;
    bus.b_wdata = bwdata;
    bus.b_be    = bbe;
    bus.c_req   = creq;
    bus.c_addr  = caddr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ramRdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 + i;

    // Reset held two cycles with the CPU requesting
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 1, 32'h0);
    checkOutput("rst1_c_gnt", bus.c_gnt, 0);
    checkOutput("rst1_mem_req", bus.mem_req, 0);
    checkOutput("rst1_c_rvalid", bus.c_rvalid, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 1, 32'h0);
    checkOutput("rst2_c_gnt", bus.c_gnt, 0);
    checkOutput("rst2_mem_req", bus.mem_req, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("rst_owner", ownerBoot, 0);
    checkOutput("rst_wr_cnt", bootWrCnt, 0);
    checkOutput("rst_err_cnt", bootErrCnt, 0);
    checkOutput("rst_c_rvalid", bus.c_rvalid, 0);

    // Drain: read 0x0 granted, boot_active rises with read 0x4
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 32'h0);
    checkOutput("drain_gnt0", bus.c_gnt, 1);
    checkOutput("drain_mem_req0", bus.mem_req, 1);
    checkOutput("drain_mem_we0", bus.mem_we, 0);
    checkOutput("drain_mem_be0", bus.mem_be, 32'hF);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 1, 32'h4);
    checkOutput("drain_gnt4", bus.c_gnt, 0);
    checkOutput("drain_rvalid", bus.c_rvalid, 1);
    checkOutput("drain_rdata", bus.c_rdata, 32'hA000_0000);
    applyStimulus(0, 1, 1, 1, 32'h100, 32'h5555_5555, 4'h1, 0, 32'h0);
    checkOutput("drain_b_gnt", bus.b_gnt, 0);
    checkOutput("drain_owner", ownerBoot, 0);
    checkOutput("drain_rvalid_off", bus.c_rvalid, 0);

    // Boot load of 16 bytes, CPU keeps requesting
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 1, 1, 32'h100 + i, 32'h5555_5555, 4'(1 << (i % 4)), 1, 32'h0);
      checkOutput("boot_owner", ownerBoot, 1);
      checkOutput("boot_b_gnt", bus.b_gnt, 1);
      checkOutput("boot_mem_req", bus.mem_req, 1);
      checkOutput("boot_mem_we", bus.mem_we, 1);
      checkOutput("boot_mem_addr", bus.mem_addr, 32'h100 + i);
      checkOutput("boot_mem_be", bus.mem_be, 32'(1 << (i % 4)));
      checkOutput("boot_c_gnt", bus.c_gnt, 0);
      checkOutput("boot_wr_cnt_run", bootWrCnt, i);
    end
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("boot_wr_cnt16", bootWrCnt, 16);

    // Error path: reads from the loader are granted, counted, not forwarded
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 32'h200, 0, 4'hF, 0, 32'h0);
      checkOutput("err_b_gnt", bus.b_gnt, 1);
      checkOutput("err_mem_req", bus.mem_req, 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("err_cnt3", bootErrCnt, 3);
    for (int i = 0; i < 297; i++) applyStimulus(0, 1, 1, 0, 32'h200, 0, 4'hF, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("err_cnt_sat", bootErrCnt, 255);
    checkOutput("err_wr_cnt_kept", bootWrCnt, 16);

    // Release: one idle cycle, then CPU reads back the loaded word
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 32'h100);
    checkOutput("rel_last_boot_c_gnt", bus.c_gnt, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 32'h100);
    checkOutput("rel_owner", ownerBoot, 0);
    checkOutput("rel_mem_req", bus.mem_req, 0);
    checkOutput("rel_c_gnt", bus.c_gnt, 0);
    applyStimulus(0, 0, 1, 1, 32'h300, 32'h1, 4'hF, 1, 32'h100);
    checkOutput("cpu_c_gnt", bus.c_gnt, 1);
    checkOutput("cpu_b_gnt_held", bus.b_gnt, 0);
    checkOutput("cpu_mem_addr", bus.mem_addr, 32'h100);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("cpu_rvalid", bus.c_rvalid, 1);
    checkOutput("cpu_rdata", bus.c_rdata, 32'h5555_5555);

    // Abort: boot_active pulses for a single cycle
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("abort_owner0", ownerBoot, 0);
    applyStimulus(0, 0, 1, 1, 32'h300, 32'h1, 4'hF, 0, 32'h0);
    checkOutput("abort_drain_b_gnt", bus.b_gnt, 0);
    checkOutput("abort_drain_owner", ownerBoot, 0);
    applyStimulus(0, 0, 1, 1, 32'h300, 32'h1, 4'hF, 1, 32'h8);
    checkOutput("abort_cpu_c_gnt", bus.c_gnt, 1);
    checkOutput("abort_b_gnt", bus.b_gnt, 0);
    checkOutput("abort_wr_cnt", bootWrCnt, 16);

    // Reset with a read in flight discards its return
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("midrst_rvalid", bus.c_rvalid, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    checkOutput("midrst_rvalid_after", bus.c_rvalid, 0);
    checkOutput("midrst_wr_cnt", bootWrCnt, 0);
    checkOutput("midrst_err_cnt", bootErrCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
